riscv_core_id_ex_skid_reg: RTL

//  ID->EX pipeline register with 2-entry skid buffer and valid/ready handshake.

---
 rtl/riscv_core_id_ex_skid_reg.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_core_id_ex_skid_reg.sv
// riscv_core_id_ex_skid_reg
//   ID->EX pipeline register with a 2-entry skid buffer and a valid/ready handshake.
//   The MAIN register drives the EX outputs. The SKID register catches one extra
//   entry when EX stalls. Because of this, o_id_ready is a plain flop and never
//   depends combinationally on i_ex_ready.
//   Downstream, operand B is selected as o_ex_alu_src ? o_ex_imm : o_ex_rs2_data.
//
// Ports
//   i_clk, i_rst                  clock and synchronous active-high reset
//   i_id_valid / o_id_ready       ID-side handshake (ready is registered)
//   i_id_rs1_data, i_id_rs2_data  decoded register operands
//   i_id_imm                      sign-extended immediate
//   i_id_alu_src                  0: rs2, 1: imm
//   i_id_rd_addr, i_id_ctrl       destination register and opaque EX control
//   i_flush                       discards every held entry and any same-cycle input
//   o_ex_valid / i_ex_ready       EX-side handshake
//   o_ex_*                        registered entry; ctrl and alu_src read 0 in a bubble
//   o_stall_cnt, o_flush_cnt      performance counters
//
// Configuration
//   RISCV_CORE_ID_EX_PERF_EN      enables the saturating performance counters.
//                                 When it is undefined, both counter outputs are tied to 0.
module riscv_core_id_ex_skid_reg #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH     = 8,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    output logic                      o_id_ready,
    input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     i_id_imm,
    input  logic                      i_id_alu_src,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
    input  logic [CTRL_WIDTH-1:0]     i_id_ctrl,
    input  logic                      i_flush,
    output logic                      o_ex_valid,
    input  logic                      i_ex_ready,
    output logic [DATA_WIDTH-1:0]     o_ex_rs1_data,
    output logic [DATA_WIDTH-1:0]     o_ex_rs2_data,
    output logic [DATA_WIDTH-1:0]     o_ex_imm,
    output logic                      o_ex_alu_src,
    output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
    output logic [CTRL_WIDTH-1:0]     o_ex_ctrl,
    output logic [PERF_CNT_WIDTH-1:0] o_stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] o_flush_cnt
);

    // Entry layout, LSB first: rs1, rs2, imm, alu_src, rd, ctrl
    localparam int unsigned OFF_RS2 = DATA_WIDTH;
    localparam int unsigned OFF_IMM = 2 * DATA_WIDTH;
    localparam int unsigned OFF_SRC = 3 * DATA_WIDTH;
    localparam int unsigned OFF_RD  = OFF_SRC + 1;
    localparam int unsigned OFF_CTL = OFF_RD + REG_ADDR_WIDTH;
    localparam int unsigned ENTRY_W = OFF_CTL + CTRL_WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_d;
    logic               r_id_ready;
    logic [ENTRY_W-1:0] r_main;
    logic [ENTRY_W-1:0] r_skid;
    logic [ENTRY_W-1:0] w_in_entry;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_ex_valid;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;

    assign w_in_entry = {i_id_ctrl, i_id_rd_addr, i_id_alu_src, i_id_imm, i_id_rs2_data,
                         i_id_rs1_data};
    assign w_ex_valid = (r_state != ST_EMPTY);
    assign w_in_xfer  = i_id_valid & r_id_ready;
    assign w_out_xfer = w_ex_valid & i_ex_ready;

    always_comb begin
        w_state_d        = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            // Any same-cycle input is dropped. A same-cycle output was already sampled by EX.
            w_state_d = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_d      = ST_FULL;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_d   = ST_SKID;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_d        = ST_FULL;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_EMPTY;
            r_id_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_id_ready <= (w_state_d != ST_SKID);
            // Data flops only load on a real move, so they hold their value while invalid.
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign o_id_ready    = r_id_ready;
    assign o_ex_valid    = w_ex_valid;
    assign o_ex_rs1_data = r_main[DATA_WIDTH-1:0];
    assign o_ex_rs2_data = r_main[OFF_IMM-1:OFF_RS2];
    assign o_ex_imm      = r_main[OFF_SRC-1:OFF_IMM];
    assign o_ex_rd_addr  = r_main[OFF_CTL-1:OFF_RD];
    // A bubble presents as a NOP with operand B taken from rs2.
    assign o_ex_alu_src  = r_main[OFF_SRC] & w_ex_valid;
    assign o_ex_ctrl     = w_ex_valid ? r_main[ENTRY_W-1:OFF_CTL] : '0;

`ifdef RISCV_CORE_ID_EX_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] r_stall_cnt;
    logic [PERF_CNT_WIDTH-1:0] r_flush_cnt;
    logic                      w_flush_kill;

    // A held entry dies unless it is MAIN and EX takes it in the flush cycle.
    assign w_flush_kill = i_flush & ((r_state == ST_SKID) | ((r_state == ST_FULL) & ~i_ex_ready));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ex_valid && !i_ex_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_CNT_WIDTH'(1);
            end
            if (w_flush_kill && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_CNT_WIDTH'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
